// File: rtl/univ_shift_reg.sv
// Universal WIDTH-bit register: hold, shift right/left, parallel load, set/reset, saturating shift counter.
// Optional rotate input enabled by defining UNIV_SHIFT_REG_ROTATE_EN.
module univ_shift_reg #(
    parameter int               WIDTH     = 8,
    parameter int               CNT_W     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter logic [WIDTH-1:0] SET_VAL   = '1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             set,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_msb,
    input  logic             sin_lsb,
`ifdef UNIV_SHIFT_REG_ROTATE_EN
    input  logic             rotate,
`endif
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic             sout_msb,
    output logic             sout_lsb,
    output logic [CNT_W-1:0] shift_cnt,
    output logic             cnt_sat
);

    typedef enum logic [1:0] {
        MODE_HOLD  = 2'b00,
        MODE_SHR   = 2'b01,
        MODE_SHL   = 2'b10,
        MODE_LOAD  = 2'b11
    } mode_e;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] q_q, q_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] shr_val, shl_val;
    logic             fill_msb, fill_lsb;
    logic [CNT_W-1:0] cnt_inc;

    // Shifted images built bit by bit so WIDTH=1 needs no special slicing.
    always_comb begin
        fill_msb = sin_msb;
        fill_lsb = sin_lsb;
`ifdef UNIV_SHIFT_REG_ROTATE_EN
        if (rotate) begin
            fill_msb = q_q[0];
            fill_lsb = q_q[WIDTH-1];
        end
`endif
        shr_val          = q_q;
        shl_val          = q_q;
        shr_val[WIDTH-1] = fill_msb;
        shl_val[0]       = fill_lsb;
        for (int i = 0; i < WIDTH - 1; i++) begin
            shr_val[i]   = q_q[i+1];
            shl_val[i+1] = q_q[i];
        end
        cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    end

    always_comb begin
        q_d   = q_q;
        cnt_d = cnt_q;
        if (set) begin
            q_d   = SET_VAL;
            cnt_d = '0;
        end else if (en) begin
            case (mode_e'(mode))
                MODE_HOLD: ;
                MODE_SHR: begin
                    q_d   = shr_val;
                    cnt_d = cnt_inc;
                end
                MODE_SHL: begin
                    q_d   = shl_val;
                    cnt_d = cnt_inc;
                end
                MODE_LOAD: begin
                    q_d   = d;
                    cnt_d = '0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q   <= RESET_VAL;
            cnt_q <= '0;
        end else begin
            q_q   <= q_d;
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        q         = q_q;
        qbar      = ~q_q;
        sout_msb  = q_q[WIDTH-1];
        sout_lsb  = q_q[0];
        shift_cnt = cnt_q;
        cnt_sat   = (cnt_q == CNT_MAX);
    end

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed self-checking bench for univ_shift_reg (WIDTH=8, CNT_W=4).
// Rotate checks are included when UNIV_SHIFT_REG_ROTATE_EN is defined.
module tb_univ_shift_reg;

    logic       clk;
    logic       reset;
    logic       set;
    logic       en;
    logic [1:0] mode;
    logic [7:0] d;
    logic       sin_msb;
    logic       sin_lsb;
    logic       rotate;
    logic [7:0] q;
    logic [7:0] qbar;
    logic       sout_msb;
    logic       sout_lsb;
    logic [3:0] shift_cnt;
    logic       cnt_sat;

    int assertCount;
    int failCount;

    univ_shift_reg #(
        .WIDTH(8),
        .CNT_W(4),
        .RESET_VAL(8'h00),
        .SET_VAL(8'hFF)
    ) dut (
        .clk(clk),
        .reset(reset),
        .set(set),
        .en(en),
        .mode(mode),
        .d(d),
        .sin_msb(sin_msb),
        .sin_lsb(sin_lsb),
`ifdef UNIV_SHIFT_REG_ROTATE_EN
        .rotate(rotate),
`endif
        .q(q),
        .qbar(qbar),
        .sout_msb(sout_msb),
        .sout_lsb(sout_lsb),
        .shift_cnt(shift_cnt),
        .cnt_sat(cnt_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Drives one operation, lets it take effect on the next rising edge, then samples 1ns later.
    task automatic applyStimulus(input logic r, input logic s, input logic e, input logic [1:0] m,
                                 input logic [7:0] dv, input logic smsb, input logic slsb);
        reset   = r;
        set     = s;
        en      = e;
        mode    = m;
        d       = dv;
        sin_msb = smsb;
        sin_lsb = slsb;
        @(posedge clk);
        #1;
    endtask

    logic [7:0] expQ;

    initial begin
        assertCount = 0;
        failCount   = 0;
        reset = 1'b0; set = 1'b0; en = 1'b0; mode = 2'b00;
        d = 8'h00; sin_msb = 1'b0; sin_lsb = 1'b0; rotate = 1'b0;
        #2;

        // Reset then load
        applyStimulus(1, 0, 1, 2'b00, 8'h00, 0, 0);
        checkOutput("reset_q", q, 8'h00);
        checkOutput("reset_qbar", qbar, 8'hFF);
        checkOutput("reset_cnt", shift_cnt, 0);
        checkOutput("reset_sat", cnt_sat, 0);
        applyStimulus(0, 0, 1, 2'b11, 8'hA5, 0, 0);
        checkOutput("load_q", q, 8'hA5);
        checkOutput("load_qbar", qbar, 8'h5A);
        checkOutput("load_cnt", shift_cnt, 0);
        checkOutput("load_sout_msb", sout_msb, 1);
        checkOutput("load_sout_lsb", sout_lsb, 1);

        // Shift right then left
        applyStimulus(0, 0, 1, 2'b01, 8'h00, 1, 0);
        checkOutput("shr_q", q, 8'hD2);
        checkOutput("shr_sout_lsb", sout_lsb, 0);
        checkOutput("shr_cnt", shift_cnt, 1);
        applyStimulus(0, 0, 1, 2'b10, 8'h00, 1, 0);
        checkOutput("shl_q", q, 8'hA4);
        checkOutput("shl_cnt", shift_cnt, 2);

        // Hold for five edges
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 0, 1, 2'b00, 8'hFF, 1, 1);
            checkOutput("hold_q", q, 8'hA4);
            checkOutput("hold_cnt", shift_cnt, 2);
        end

        // Saturation over 20 right shifts of ones
        applyStimulus(0, 0, 1, 2'b11, 8'h00, 0, 0);
        checkOutput("sat_load_cnt", shift_cnt, 0);
        expQ = 8'h00;
        for (int k = 1; k <= 20; k++) begin
            applyStimulus(0, 0, 1, 2'b01, 8'h00, 1, 0);
            expQ = {1'b1, expQ[7:1]};
            checkOutput("sat_q", q, expQ);
            checkOutput("sat_cnt", shift_cnt, (k >= 15) ? 15 : k);
            checkOutput("sat_flag", cnt_sat, (k >= 15) ? 1 : 0);
        end
        checkOutput("sat_final_q", q, 8'hFF);

        // Reset aborts a shift run
        applyStimulus(1, 0, 1, 2'b01, 8'h00, 1, 0);
        checkOutput("abort_q", q, 8'h00);
        checkOutput("abort_cnt", shift_cnt, 0);
        checkOutput("abort_sat", cnt_sat, 0);

        // Priority: reset beats set, set ignores en, en=0 blocks load and shift
        applyStimulus(0, 0, 1, 2'b11, 8'h5A, 0, 0);
        applyStimulus(1, 1, 1, 2'b11, 8'h5A, 0, 0);
        checkOutput("rst_set_q", q, 8'h00);
        applyStimulus(0, 0, 1, 2'b10, 8'h00, 0, 1);
        applyStimulus(0, 0, 1, 2'b10, 8'h00, 0, 1);
        checkOutput("pre_set_q", q, 8'h03);
        checkOutput("pre_set_cnt", shift_cnt, 2);
        applyStimulus(0, 1, 0, 2'b00, 8'h00, 0, 0);
        checkOutput("set_noen_q", q, 8'hFF);
        checkOutput("set_noen_cnt", shift_cnt, 0);
        applyStimulus(0, 0, 0, 2'b11, 8'h3C, 0, 0);
        checkOutput("noen_load_q", q, 8'hFF);
        applyStimulus(0, 0, 0, 2'b01, 8'h00, 0, 0);
        checkOutput("noen_shr_q", q, 8'hFF);
        checkOutput("noen_shr_cnt", shift_cnt, 0);

`ifdef UNIV_SHIFT_REG_ROTATE_EN
        // Rotate left then right returns the pattern and counts both
        applyStimulus(0, 0, 1, 2'b11, 8'h81, 0, 0);
        rotate = 1'b1;
        applyStimulus(0, 0, 1, 2'b10, 8'h00, 0, 0);
        checkOutput("rotl_q", q, 8'h03);
        applyStimulus(0, 0, 1, 2'b01, 8'h00, 0, 0);
        checkOutput("rotr_q", q, 8'h81);
        checkOutput("rot_cnt", shift_cnt, 2);
        rotate = 1'b0;
        applyStimulus(0, 0, 1, 2'b01, 8'h00, 0, 0);
        checkOutput("norot_q", q, 8'h40);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/univ_shift_reg.md
# univ_shift_reg

Parametrised universal register that generalises the single-bit D flip-flop with set/reset into a WIDTH-bit storage element. It supports hold, shift right, shift left and parallel load, plus synchronous set and reset and complementary outputs. It also keeps a saturating count of shifts performed since the last load. It serves as the building block for serial/parallel converters and delay lines in the course designs.

## Interface
- `WIDTH`, 8, register width in bits (>= 1)
- `CNT_W`, 4, width of the shift counter (>= 1)
- `RESET_VAL`, 0, value loaded into `q` on `reset`
- `SET_VAL`, all ones, value loaded into `q` on `set`

- `clk`  input  1  clock; all state updates on the rising edge
- `reset`  input  1  synchronous, active-high reset
- `set`  input  1  synchronous, active-high preset; lower priority than `reset`
- `en`  input  1  clock enable for `mode` operations
- `mode`  input  2  00 hold, 01 shift right, 10 shift left, 11 parallel load
- `d`  input  WIDTH  parallel load data
- `sin_msb`  input  1  serial input entering at bit WIDTH-1 on shift right
- `sin_lsb`  input  1  serial input entering at bit 0 on shift left
- `q`  output  WIDTH  register contents
- `qbar`  output  WIDTH  bitwise complement of `q`
- `sout_msb`  output  1  `q[WIDTH-1]`
- `sout_lsb`  output  1  `q[0]`
- `shift_cnt`  output  CNT_W  number of shifts since the last load, set or reset; saturates
- `cnt_sat`  output  1  high when `shift_cnt` equals 2^CNT_W-1

## Operation
- Per-edge priority: `reset` > `set` > `en`=0 > `mode`.
- `reset`: `q`=RESET_VAL, `shift_cnt`=0.
- `set` (with `reset`=0): `q`=SET_VAL, `shift_cnt`=0.
- `en`=0: all state holds, regardless of `mode`.
- Mode 00: hold; `shift_cnt` is unchanged.
- Mode 01: `q` <= {`sin_msb`, `q[WIDTH-1:1]`}; the bit shifted out was `q[0]`.
- Mode 10: `q` <= {`q[WIDTH-2:0]`, `sin_lsb`}; the bit shifted out was `q[WIDTH-1]`.
- Modes 01 and 10 increment `shift_cnt` by 1 and hold it at 2^CNT_W-1 once reached; the counter never wraps.
- Mode 11: `q` <= `d`, `shift_cnt` <= 0.
- WIDTH=1: mode 01 gives `q`<=`sin_msb`, mode 10 gives `q`<=`sin_lsb`; there is no out-of-range slice.
- `qbar`, `sout_msb`, `sout_lsb` and `cnt_sat` are combinational decodes of the registered state. They never glitch relative to `q`.
- No internal state exists beyond `q` and `shift_cnt`.

## Timing
- Single clock domain. Outputs change only after the rising edge of `clk`.
- Latency is 1 cycle: the operation sampled at edge N is visible after edge N.
- Reset values: `q`=RESET_VAL, `qbar`=~RESET_VAL, `shift_cnt`=0, `cnt_sat`=0 (unless CNT_W saturation is 0, which is impossible).
- Reset asserted mid-shift-sequence aborts it on that edge. The counter clears and there is no residual effect.
- `reset` and `set` asserted together: reset wins.
- `set` with `en`=0: set still takes effect, because `set` does not depend on `en`.
- Before the first reset edge, outputs are X; the bench must apply reset first.

## Configuration
- Macro: `UNIV_SHIFT_REG_ROTATE_EN`.
- Defined: adds input port `rotate` (1 bit) after `sin_lsb`.
  - When `rotate`=1, mode 01 uses `q[0]` in place of `sin_msb` (rotate right).
  - When `rotate`=1, mode 10 uses `q[WIDTH-1]` in place of `sin_lsb` (rotate left).
  - Rotations count as shifts.
  - `rotate`=0 behaves exactly as in the undefined case.
- Undefined: no `rotate` port; shifts always take the serial inputs.

## Test plan
All scenarios use WIDTH=8, CNT_W=4, RESET_VAL=0, SET_VAL=8'hFF.
- Reset then load: `reset`=1 for one edge, then mode 11 with `d`=8'hA5. Expect `q`=8'h00/`qbar`=8'hFF after reset, then `q`=8'hA5, `qbar`=8'h5A, `shift_cnt`=0.
- Shift right: from 8'hA5, mode 01 with `sin_msb`=1 for 1 edge. Expect `q`=8'hD2, `sout_lsb`=0, `shift_cnt`=1. Then mode 10 with `sin_lsb`=0. Expect `q`=8'hA4, `shift_cnt`=2.
- Saturation: 20 consecutive mode-01 edges after a load. Expect `shift_cnt` stops at 15, `cnt_sat`=1 from the 15th edge on, and `q`=8'hFF if `sin_msb`=1 throughout.
- Priority: `reset`=1 and `set`=1 together give `q`=8'h00. `set`=1 with `en`=0 gives `q`=8'hFF and `shift_cnt`=0. `en`=0 with mode 11 and `d`=8'h3C leaves `q` unchanged.
- Hold: mode 00 with `en`=1 for 5 edges. Expect `q` and `shift_cnt` unchanged.
- Rotate (macro defined): load 8'h81, `rotate`=1, mode 10 for one edge. Expect `q`=8'h03. Then mode 01 for one edge. Expect `q`=8'h81 and `shift_cnt`=2.
